// File: rtl/imm_decode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg: shared definitions for the decode-stage immediate controller.
//   - RV opcode constants (instr[6:0])
//   - immediate-format select encoding (IMM_I .. IMM_CSR)
//   - decode_slot_t: one pipeline slot, used for both the main and skid registers
//   - state_t: slot occupancy state of the controller
// Optional feature macro used by the importing modules: IMM_DECODE_CSR_EN
// -----------------------------------------------------------------------------
package imm_pkg;

  localparam int DATA_W = 32;
  localparam int SRC_W  = 3;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Immediate-format select encoding
  localparam logic [SRC_W-1:0] IMM_I    = 3'b000;
  localparam logic [SRC_W-1:0] IMM_S    = 3'b001;
  localparam logic [SRC_W-1:0] IMM_B    = 3'b010;
  localparam logic [SRC_W-1:0] IMM_J    = 3'b011;
  localparam logic [SRC_W-1:0] IMM_UIMM = 3'b100;
  localparam logic [SRC_W-1:0] IMM_U    = 3'b101;
  localparam logic [SRC_W-1:0] IMM_CSR  = 3'b110;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [SRC_W-1:0]  imm_src;
    logic              has_imm;
    logic              illegal;
  } decode_slot_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b01,
    ST_FULL2 = 2'b10
  } state_t;

endpackage

// File: rtl/imm_decode_ctrl_extend.sv
// -----------------------------------------------------------------------------
// imm_extend: immediate extender. Builds the 32-bit immediate for the
// selected format from the instruction body.
// Ports:
//   instr   in  25 instr[31:7] (opcode bits are not needed)
//   imm_src in  3  format select
//   imm     out 32 extended immediate (0 for unknown selects)
// -----------------------------------------------------------------------------
module imm_extend
  import imm_pkg::*;
(
  input  logic [31:7]       instr,
  input  logic [SRC_W-1:0]  imm_src,
  output logic [DATA_W-1:0] imm
);

  // Assemble and extend the immediate for the requested format
  always_comb begin
    imm = 32'h0000_0000;
    case (imm_src)
      IMM_I:    imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_UIMM: imm = {27'h0, instr[24:20]};
      IMM_U:    imm = {instr[31:12], 12'h000};
      IMM_CSR:  imm = {27'h0, instr[19:15]};
      default:  imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl_src_decode.sv
// -----------------------------------------------------------------------------
// imm_src_decode: combinational opcode classifier.
// Ports:
//   opcode  in  7  instr[6:0]
//   funct3  in  3  instr[14:12]
//   imm_src out 3  immediate-format select for the extender
//   has_imm out 1  instruction carries an immediate
//   illegal out 1  opcode not recognised
// Optional: IMM_DECODE_CSR_EN routes csrrwi/csrrsi/csrrci to IMM_CSR.
// -----------------------------------------------------------------------------
module imm_src_decode
  import imm_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  output logic [SRC_W-1:0] imm_src,
  output logic             has_imm,
  output logic             illegal
);

  // Classify the opcode into a format select plus immediate/illegal flags
  always_comb begin
    imm_src = IMM_I;
    has_imm = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_LOAD_FP, OPC_JALR: begin
        imm_src = IMM_I;
        has_imm = 1'b1;
      end
      OPC_SYSTEM: begin
        has_imm = 1'b1;
`ifdef IMM_DECODE_CSR_EN
        // funct3[2] set marks the immediate-operand CSR forms (101/110/111)
        if (funct3[2] && (funct3[1:0] != 2'b00)) begin
          imm_src = IMM_CSR;
        end else begin
          imm_src = IMM_I;
        end
`else
        imm_src = IMM_I;
`endif
      end
      OPC_OP_IMM: begin
        has_imm = 1'b1;
        // slli/srli/srai take a 5-bit shift amount instead of a signed imm
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          imm_src = IMM_UIMM;
        end else begin
          imm_src = IMM_I;
        end
      end
      OPC_STORE, OPC_STORE_FP: begin
        imm_src = IMM_S;
        has_imm = 1'b1;
      end
      OPC_BRANCH: begin
        imm_src = IMM_B;
        has_imm = 1'b1;
      end
      OPC_JAL: begin
        imm_src = IMM_J;
        has_imm = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_src = IMM_U;
        has_imm = 1'b1;
      end
      OPC_OP, OPC_OP_FP: begin
        imm_src = IMM_I;
        has_imm = 1'b0;
      end
      default: begin
        imm_src = IMM_I;
        has_imm = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// -----------------------------------------------------------------------------
// imm_decode_ctrl: decode-stage controller around the immediate extender.
// Decodes the incoming instruction on the input path and registers
// {instr, pc, imm, imm_src, has_imm, illegal} into a valid/ready slot backed
// by a one-word skid register, so a full-rate stream survives backpressure.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   flush          drop held and incoming instructions (branch redirect)
//   in_valid/in_ready/in_instr/in_pc        upstream handshake + payload
//   out_valid/out_ready                     downstream handshake
//   out_instr/out_pc/out_imm/out_imm_src/out_has_imm/out_illegal  decoded slot
// Optional: IMM_DECODE_CSR_EN (zero-extended uimm for csrr*i, select 110).
// -----------------------------------------------------------------------------
module imm_decode_ctrl
  import imm_pkg::*;
#(
  parameter int XLEN      = DATA_W,
  parameter int IMM_SRC_W = SRC_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_instr,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [IMM_SRC_W-1:0] out_imm_src,
  output logic                 out_has_imm,
  output logic                 out_illegal
);

  state_t           state_r;
  decode_slot_t     main_r;
  decode_slot_t     skid_r;
  decode_slot_t     in_slot_s;
  logic             out_valid_r;
  logic             in_ready_r;
  logic [SRC_W-1:0] imm_src_s;
  logic             has_imm_s;
  logic             illegal_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic             in_fire_s;
  logic             out_fire_s;

  imm_src_decode u_src_decode (
    .opcode  (in_instr[6:0]),
    .funct3  (in_instr[14:12]),
    .imm_src (imm_src_s),
    .has_imm (has_imm_s),
    .illegal (illegal_s)
  );

  imm_extend u_extend (
    .instr   (in_instr[31:7]),
    .imm_src (imm_src_s),
    .imm     (imm_ext_s)
  );

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Pack the decoded input word; instructions without an immediate carry 0
  always_comb begin
    in_slot_s.instr   = in_instr;
    in_slot_s.pc      = in_pc;
    in_slot_s.imm_src = imm_src_s;
    in_slot_s.has_imm = has_imm_s;
    in_slot_s.illegal = illegal_s;
    if (has_imm_s) begin
      in_slot_s.imm = imm_ext_s;
    end else begin
      in_slot_s.imm = 32'h0000_0000;
    end
  end

  // Slot occupancy FSM with registered handshake outputs; flush beats handshakes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_r      <= in_slot_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_FULL1;
          end
        end
        ST_FULL1: begin
          if (in_fire_s && out_fire_s) begin
            main_r <= in_slot_s;
          end else if (in_fire_s) begin
            // Downstream stalled: park the new word behind the main slot
            skid_r     <= in_slot_s;
            in_ready_r <= 1'b0;
            state_r    <= ST_FULL2;
          end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_EMPTY;
          end
        end
        ST_FULL2: begin
          if (out_fire_s) begin
            main_r     <= skid_r;
            skid_r     <= '0;
            in_ready_r <= 1'b1;
            state_r    <= ST_FULL1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          skid_r      <= '0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_instr   = main_r.instr;
  assign out_pc      = main_r.pc;
  assign out_imm     = main_r.imm;
  assign out_imm_src = main_r.imm_src;
  assign out_has_imm = main_r.has_imm;
  assign out_illegal = main_r.illegal;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for imm_decode_ctrl: the driver pushes the hand-computed
// expected slot when a word is accepted, the monitor pops and compares on
// every output transfer.
// -----------------------------------------------------------------------------
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
  logic [2:0]  out_imm_src;
  logic        out_has_imm, out_illegal;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  src;
    logic        has_imm;
    logic        illegal;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   fails  = 0;

  // Stability tracking for stalled outputs
  logic        stall_prev = 1'b0;
  logic [31:0] instr_prev = 32'h0;
  logic [31:0] imm_prev   = 32'h0;

  always #5 clk = ~clk;

  imm_decode_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_imm_src (out_imm_src),
    .out_has_imm (out_has_imm),
    .out_illegal (out_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [2:0] src,
                              input logic has_imm, input logic illegal);
    exp_t e;
    e.instr = instr; e.pc = pc; e.imm = imm; e.src = src;
    e.has_imm = has_imm; e.illegal = illegal;
    return e;
  endfunction

  // Monitor: compare every output transfer against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid && stall_prev) begin
      check("stable_instr", out_instr, instr_prev);
      check("stable_imm", out_imm, imm_prev);
    end
    if (rstn && out_valid && out_ready && !flush) begin
      if (expq.size() == 0) begin
        check("unexpected_output", out_instr, 32'hdead_beef);
      end else begin
        e = expq.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_pc", out_pc, e.pc);
        check("out_imm", out_imm, e.imm);
        check("out_imm_src", {29'h0, out_imm_src}, {29'h0, e.src});
        check("out_has_imm", {31'h0, out_has_imm}, {31'h0, e.has_imm});
        check("out_illegal", {31'h0, out_illegal}, {31'h0, e.illegal});
      end
    end
    stall_prev = rstn && out_valid && !out_ready && !flush;
    instr_prev = out_instr;
    imm_prev   = out_imm;
  end

  // Present one word until accepted; expected value queued at acceptance
  task automatic send(input exp_t e);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_instr = e.instr; in_pc = e.pc;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        expq.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'h0, 32'h1);
  endtask

  // Wait until every queued word has emerged (bounded)
  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", expq.size(), 32'h0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    cycles(3);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_imm", out_imm, 32'h0);
    rstn = 1'b1;
    cycles(1);

    // Single addi, 1-cycle latency
    out_ready = 1'b1;
    send(mk(32'hfff00093, 32'h0000_1000, 32'hffffffff, 3'b000, 1'b1, 1'b0));
    check("latency_out_valid", {31'h0, out_valid}, 32'h1);
    drain();

    // Back-to-back stream of formats
    send(mk(32'h00112623, 32'h0000_1004, 32'h0000000c, 3'b001, 1'b1, 1'b0));
    send(mk(32'h01f09093, 32'h0000_1008, 32'h0000001f, 3'b100, 1'b1, 1'b0));
    send(mk(32'h123450b7, 32'h0000_100c, 32'h12345000, 3'b101, 1'b1, 1'b0));
    send(mk(32'hffdff06f, 32'h0000_1010, 32'hfffffffc, 3'b011, 1'b1, 1'b0));
    drain();

    // Illegal opcode, R-type
    send(mk(32'h0000007f, 32'h0000_1014, 32'h00000000, 3'b000, 1'b0, 1'b1));
    send(mk(32'h00000033, 32'h0000_1018, 32'h00000000, 3'b000, 1'b0, 1'b0));
    drain();

    // CSR immediate form
`ifdef IMM_DECODE_CSR_EN
    send(mk(32'h3002d073, 32'h0000_101c, 32'h00000005, 3'b110, 1'b1, 1'b0));
`else
    send(mk(32'h3002d073, 32'h0000_101c, 32'h00000300, 3'b000, 1'b1, 1'b0));
`endif
    drain();

    // Backpressure: two fill main+skid, third held upstream
    out_ready = 1'b0;
    send(mk(32'h00500113, 32'h0000_2000, 32'h00000005, 3'b000, 1'b1, 1'b0));
    check("bp_in_ready_after_1", {31'h0, in_ready}, 32'h1);
    send(mk(32'hff010113, 32'h0000_2004, 32'hfffffff0, 3'b000, 1'b1, 1'b0));
    check("bp_in_ready_after_2", {31'h0, in_ready}, 32'h0);
    fork
      send(mk(32'h00208463, 32'h0000_2008, 32'h00000008, 3'b010, 1'b1, 1'b0));
    join_none
    cycles(3);
    check("bp_in_ready_held", {31'h0, in_ready}, 32'h0);
    check("bp_out_head", out_instr, 32'h00500113);
    check("bp_queue_depth", expq.size(), 32'h2);
    out_ready = 1'b1;
    drain();
    wait fork;

    // Flush in FULL2 with a word arriving
    out_ready = 1'b0;
    send(mk(32'h00100093, 32'h0000_3000, 32'h00000001, 3'b000, 1'b1, 1'b0));
    send(mk(32'h00200093, 32'h0000_3004, 32'h00000002, 3'b000, 1'b1, 1'b0));
    in_valid = 1'b1; in_instr = 32'h00300093; in_pc = 32'h0000_3008;
    flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    expq.delete();
    check("flush_out_valid", {31'h0, out_valid}, 32'h0);
    check("flush_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    cycles(4);
    check("flush_stays_empty", {31'h0, out_valid}, 32'h0);
    send(mk(32'h00400093, 32'h0000_300c, 32'h00000004, 3'b000, 1'b1, 1'b0));
    drain();

    // Reset mid-operation clears data outputs
    out_ready = 1'b0;
    send(mk(32'h0ff00093, 32'h0000_4000, 32'h000000ff, 3'b000, 1'b1, 1'b0));
    rstn = 1'b0;
    cycles(1);
    expq.delete();
    rstn = 1'b1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_out_instr", out_instr, 32'h0);
    check("midrst_out_pc", out_pc, 32'h0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
